alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EVAL_CYCLES, default 4: clock cycles the ALU operands are held stable before the result is captured; legal range 1..15.
REQ-002 Parameter RR_INIT, default 0: requester holding priority after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-008 req0_cmd, req1_cmd  input  3 each  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-009 rsp_valid  output  1  response held for consumer.
REQ-010 rsp_ready  input  1  consumer takes response.
REQ-011 rsp_id  output  1  requester index owning the response.
REQ-012 rsp_result  output  32  captured ALU result.
REQ-013 rsp_carryout, rsp_overflow, rsp_zero  output  1 each  captured flags.

Function
REQ-014 FSM states: IDLE, EVAL, RESP.
REQ-015 reqN_ready is asserted only in IDLE, for exactly one cycle, and only to the granted requester; both readys are never high together.
REQ-016 IDLE: with one valid, grant it; with both valid, grant the priority holder; with none, stay in IDLE.
REQ-017 On grant: latch a, b and cmd into operand registers, record rsp_id, load eval counter with EVAL_CYCLES, and go to EVAL.
REQ-018 Priority passes to the non-granted requester after every grant; it is unchanged when no grant occurs.
REQ-019 Operand registers drive the ALU continuously and change only on grant.
REQ-020 EVAL: counter decrements each cycle; in the cycle it reaches 1, capture result, carryout and overflow, and compute rsp_zero as (result == 0); go to RESP.
REQ-021 rsp_valid first rises in cycle T+EVAL_CYCLES+1, where T is the cycle in which ready was high.
REQ-022 RESP: rsp_valid = 1 with all rsp_* outputs stable; when rsp_ready = 1, go to IDLE; otherwise hold indefinitely.
REQ-023 A new grant is possible no earlier than the cycle after the rsp_valid/rsp_ready handshake; at most one operation is in flight.
REQ-024 Requesters must hold valid and payload stable until ready; requests are never dropped or reordered except on reset.
REQ-025 rsp_valid, rsp_id, rsp_result and the flags are registered outputs with no combinational path from inputs.

Reset
REQ-026 On rst_n low: state = IDLE, both readys = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, all flags = 0, operand registers = 0, counter = 0, priority = RR_INIT.
REQ-027 Reset asserted during EVAL or RESP aborts the operation; no response is ever issued for it.
REQ-028 The first grant is possible in the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_ARBITER_FLAGS_EN, when defined: rsp_carryout, rsp_overflow and rsp_zero are captured per REQ-020.
REQ-030 Macro undefined: the flag outputs are tied to 0, flag capture registers are omitted, and rsp_result behaviour is unchanged.

Structure
REQ-031 A shared package holds the 3-bit command codes (ADD..OR), the FSM state encoding and the EVAL_CYCLES legal limit.
REQ-032 The block instantiates the existing 32-bit ALU as its datapath.
REQ-033 Grant and priority logic forms one sub-module, alu_rr_grant.

Verification
REQ-034 req0 ADD a=5, b=7, EVAL_CYCLES=4, ready at cycle T -> rsp_valid at T+5, rsp_id=0, result=12, zero=0.
REQ-035 req1 SUB a=3, b=3 -> result=0, zero=1, carryout=1, overflow=0, rsp_id=1.
REQ-036 Both valid continuously, RR_INIT=0, rsp_ready=1 -> grants alternate 0,1,0,1; responses carry rsp_id 0,1,0,1.
REQ-037 req0 SLT a=0xFFFFFFFF, b=1 with rsp_ready=0 for 10 cycles -> result=1 held stable, no ready asserted until rsp_ready handshake.
REQ-038 rst_n pulsed low during EVAL of ADD 0x7FFFFFFF+1 -> no response; outputs at reset values; the next request completes normally.
REQ-039 Build without ALU_ARBITER_FLAGS_EN, ADD 0xFFFFFFFF+1 -> result=0, all flags 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and limits for the two-requester ALU arbiter.
// Shared by the build with and without ALU_ARBITER_FLAGS_EN.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CMD_W           = 3;
  localparam int unsigned EVAL_CYCLES_MAX = 15;
  localparam int unsigned CNT_W           = $clog2(EVAL_CYCLES_MAX + 1);

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_cmd_e          cmd;
  } alu_op_t;

  typedef struct packed {
    logic carryout;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters, the arbiter and one consumer.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [CMD_W-1:0]  req0_cmd;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [CMD_W-1:0]  req1_cmd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carryout;
  logic              rsp_overflow;
  logic              rsp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd,
    output req1_valid, req1_a, req1_b, req1_cmd,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd,
    input  req1_valid, req1_a, req1_b, req1_cmd,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );

endinterface : alu_arbiter_if

// File: rtl/alu32.sv
// Combinational 32-bit ALU; carry/overflow are meaningful for ADD and SUB only.
module alu32
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_cmd_e          cmd_i,
  output logic [DATA_W-1:0] result_c_o,
  output logic              carryout_c_o,
  output logic              overflow_c_o
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] diff_c;
  logic             add_ovf_c;
  logic             sub_ovf_c;

  // SUB is a + ~b + 1, so carryout = 1 means no borrow
  always_comb begin
    sum_c     = {1'b0, a_i} + {1'b0, b_i};
    diff_c    = {1'b0, a_i} + {1'b0, ~b_i} + SUM_W'(1);
    add_ovf_c = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum_c[DATA_W-1] != a_i[DATA_W-1]);
    sub_ovf_c = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff_c[DATA_W-1] != a_i[DATA_W-1]);
  end

  always_comb begin
    result_c_o   = '0;
    carryout_c_o = 1'b0;
    overflow_c_o = 1'b0;
    unique case (cmd_i)
      CMD_ADD: begin
        result_c_o   = sum_c[DATA_W-1:0];
        carryout_c_o = sum_c[DATA_W];
        overflow_c_o = add_ovf_c;
      end
      CMD_SUB: begin
        result_c_o   = diff_c[DATA_W-1:0];
        carryout_c_o = diff_c[DATA_W];
        overflow_c_o = sub_ovf_c;
      end
      CMD_XOR:  result_c_o = a_i ^ b_i;
      CMD_SLT:  result_c_o = DATA_W'(diff_c[DATA_W-1] ^ sub_ovf_c);
      CMD_AND:  result_c_o = a_i & b_i;
      CMD_NAND: result_c_o = ~(a_i & b_i);
      CMD_NOR:  result_c_o = ~(a_i | b_i);
      CMD_OR:   result_c_o = a_i | b_i;
      default:  result_c_o = '0;
    endcase
  end

endmodule : alu32

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant; priority flips to the loser after every grant.
module alu_rr_grant #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_valid_i,
  input  logic req1_valid_i,
  output logic gnt0_c_o,
  output logic gnt1_c_o,
  output logic gnt_id_c_o,
  output logic gnt_any_c_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt0_c_o = 1'b0;
    gnt1_c_o = 1'b0;
    prio_d   = prio_q;
    if (en_i) begin
      if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
        gnt0_c_o = 1'b1;
      end else if (req1_valid_i) begin
        gnt1_c_o = 1'b1;
      end
    end
    if (gnt0_c_o) begin
      prio_d = 1'b1;
    end else if (gnt1_c_o) begin
      prio_d = 1'b0;
    end
  end

  assign gnt_id_c_o  = gnt1_c_o;
  assign gnt_any_c_o = gnt0_c_o | gnt1_c_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'(RR_INIT);
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : alu_rr_grant

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one ALU, one operation in flight at a time.
// Build option ALU_ARBITER_FLAGS_EN: capture carryout/overflow/zero, else tie them to 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned EVAL_CYCLES = 4,
  parameter int unsigned RR_INIT     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus_if
);

  if (EVAL_CYCLES < 1 || EVAL_CYCLES > EVAL_CYCLES_MAX) begin : g_bad_eval_cycles
    $error("EVAL_CYCLES must be within 1..15");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  alu_op_t           op_q, op_d;
  alu_op_t           op0_c, op1_c;
  logic              id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              grant_en_c;
  logic              gnt0_c, gnt1_c, gnt_id_c, gnt_any_c;
  logic              capture_c;
  logic [DATA_W-1:0] alu_result_c;
  logic              alu_carry_c, alu_ovf_c;

  assign op0_c = '{a: bus_if.req0_a, b: bus_if.req0_b, cmd: alu_cmd_e'(bus_if.req0_cmd)};
  assign op1_c = '{a: bus_if.req1_a, b: bus_if.req1_b, cmd: alu_cmd_e'(bus_if.req1_cmd)};

  // Readys must stay low while reset is held even if requesters are valid
  assign grant_en_c = (state_q == ST_IDLE) && rst_n;

  alu_rr_grant #(
    .RR_INIT (RR_INIT)
  ) u_grant (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (grant_en_c),
    .req0_valid_i (bus_if.req0_valid),
    .req1_valid_i (bus_if.req1_valid),
    .gnt0_c_o     (gnt0_c),
    .gnt1_c_o     (gnt1_c),
    .gnt_id_c_o   (gnt_id_c),
    .gnt_any_c_o  (gnt_any_c)
  );

  assign bus_if.req0_ready = gnt0_c;
  assign bus_if.req1_ready = gnt1_c;

  alu32 u_alu (
    .a_i          (op_q.a),
    .b_i          (op_q.b),
    .cmd_i        (op_q.cmd),
    .result_c_o   (alu_result_c),
    .carryout_c_o (alu_carry_c),
    .overflow_c_o (alu_ovf_c)
  );

  assign capture_c = (state_q == ST_EVAL) && (cnt_q == CNT_W'(1));

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    id_d        = id_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any_c) begin
          op_d    = gnt_id_c ? op1_c : op0_c;
          id_d    = gnt_id_c;
          cnt_d   = CNT_W'(EVAL_CYCLES);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (capture_c) begin
          result_d    = alu_result_c;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus_if.rsp_valid  = rsp_valid_q;
  assign bus_if.rsp_id     = id_q;
  assign bus_if.rsp_result = result_q;

`ifdef ALU_ARBITER_FLAGS_EN
  alu_flags_t flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (capture_c) begin
      flags_d = '{carryout: alu_carry_c, overflow: alu_ovf_c, zero: (alu_result_c == '0)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus_if.rsp_carryout = flags_q.carryout;
  assign bus_if.rsp_overflow = flags_q.overflow;
  assign bus_if.rsp_zero     = flags_q.zero;
`else
  logic unused_alu_flags;
  assign unused_alu_flags    = alu_carry_c ^ alu_ovf_c;

  assign bus_if.rsp_carryout = 1'b0;
  assign bus_if.rsp_overflow = 1'b0;
  assign bus_if.rsp_zero     = 1'b0;
`endif

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (EVAL_CYCLES=4, RR_INIT=0); flag expectations follow ALU_ARBITER_FLAGS_EN.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

`ifdef ALU_ARBITER_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_arbiter_if bus();

  alu_arbiter #(.EVAL_CYCLES(4), .RR_INIT(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input alu_cmd_e cmd, input logic v);
    if (r == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_cmd = cmd; bus.req0_valid = v;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_cmd = cmd; bus.req1_valid = v;
    end
  endtask

  task automatic wait_ready(input int r, input int max_cyc, output bit seen, output int t);
    seen = 1'b0;
    t    = -1;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (((r == 0) ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
        seen = 1'b1;
        t    = cyc;
      end
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output bit seen, output int t);
    seen = 1'b0;
    t    = -1;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        t    = cyc;
      end
    end
  endtask

  // Present a request, wait for its ready, then withdraw valid after the accepting edge
  task automatic do_req(input int r, input logic [31:0] a, input logic [31:0] b,
                        input alu_cmd_e cmd, output bit seen, output int t);
    drive_req(r, a, b, cmd, 1'b1);
    wait_ready(r, 30, seen, t);
    @(posedge clk); #1;
    if (r == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_req(0, 32'h1, 32'h2, CMD_ADD, 1'b1);
    drive_req(1, 32'h3, 32'h4, CMD_OR, 1'b1);
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
    end
    n_checks++;
    if (bus.rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id);
    end
    n_checks++;
    if (bus.rsp_result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.rsp_result);
    end
    n_checks++;
    if ({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b%b%b expected 000",
                         bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_add();
    bit seen; int t, tr, rel;
    rst_n = 1'b1;
    rel   = cyc;
    do_req(0, 32'd5, 32'd7, CMD_ADD, seen, t);
    n_checks++;
    if (!seen || t != rel) begin
      n_fail++; $display("FAIL add_first_grant: got seen=%0d cycle=%0d expected cycle %0d", seen, t, rel);
    end
    wait_rsp(20, seen, tr);
    n_checks++;
    if (!seen || tr != t + 5) begin
      n_fail++; $display("FAIL add_latency: got seen=%0d cycle=%0d expected %0d", seen, tr, t + 5);
    end
    n_checks++;
    if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd12) begin
      n_fail++; $display("FAIL add_result: got id=%b result=%h expected id=0 result=0000000c",
                         bus.rsp_id, bus.rsp_result);
    end
    n_checks++;
    if ({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero} !== 3'b000) begin
      n_fail++; $display("FAIL add_flags: got %b%b%b expected 000",
                         bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_handshake: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_sub();
    bit seen; int t, tr;
    @(posedge clk); #1;
    do_req(1, 32'd3, 32'd3, CMD_SUB, seen, t);
    wait_rsp(20, seen, tr);
    n_checks++;
    if (!seen || tr != t + 5) begin
      n_fail++; $display("FAIL sub_latency: got seen=%0d cycle=%0d expected %0d", seen, tr, t + 5);
    end
    n_checks++;
    if (bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'h0) begin
      n_fail++; $display("FAIL sub_result: got id=%b result=%h expected id=1 result=00000000",
                         bus.rsp_id, bus.rsp_result);
    end
    n_checks++;
    if ({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero} !== {FL, 1'b0, FL}) begin
      n_fail++; $display("FAIL sub_flags: got %b%b%b expected %b0%b",
                         bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, FL, FL);
    end
  endtask

  task automatic test_back_to_back();
    localparam logic [31:0] R0_RES = 32'hF000_F000;
    localparam logic [31:0] R1_RES = 32'hF0F0_FF00;
    int          g_id[$];
    int          g_t[$];
    int          r_id[$];
    logic [31:0] r_res[$];
    bit          both = 1'b0;
    @(posedge clk); #1;
    drive_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, CMD_AND, 1'b1);
    drive_req(1, 32'h0F0F_0000, 32'h0000_00FF, CMD_NOR, 1'b1);
    for (int i = 0; i < 80 && r_id.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both = 1'b1;
      if (bus.req0_ready === 1'b1) begin g_id.push_back(0); g_t.push_back(cyc); end
      if (bus.req1_ready === 1'b1) begin g_id.push_back(1); g_t.push_back(cyc); end
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        r_id.push_back(int'(bus.rsp_id));
        r_res.push_back(bus.rsp_result);
      end
      if (g_id.size() >= 4 && (bus.req0_valid || bus.req1_valid)) begin
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    n_checks++;
    if (both) begin
      n_fail++; $display("FAIL b2b_exclusive: got both readys high expected at most one");
    end
    n_checks++;
    if (g_id.size() != 4 || r_id.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got grants=%0d responses=%0d expected 4 and 4",
                         g_id.size(), r_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (g_id[k] != (k % 2) || r_id[k] != (k % 2)) begin
          n_fail++; $display("FAIL b2b_order[%0d]: got grant=%0d rsp_id=%0d expected %0d",
                             k, g_id[k], r_id[k], k % 2);
        end
        n_checks++;
        if (r_res[k] !== ((k % 2 == 0) ? R0_RES : R1_RES)) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h",
                             k, r_res[k], (k % 2 == 0) ? R0_RES : R1_RES);
        end
      end
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (g_t[k] - g_t[k-1] != 6) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 6", k, g_t[k] - g_t[k-1]);
        end
      end
    end
  endtask

  task automatic test_hold();
    bit seen; int t, tr, t1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_req(0, 32'hFFFF_FFFF, 32'h1, CMD_SLT, seen, t);
    drive_req(1, 32'h1234_0000, 32'h0000_5678, CMD_OR, 1'b1);
    wait_rsp(20, seen, tr);
    n_checks++;
    if (!seen || tr != t + 5) begin
      n_fail++; $display("FAIL hold_latency: got seen=%0d cycle=%0d expected %0d", seen, tr, t + 5);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h1 || bus.rsp_id !== 1'b0 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got valid=%b id=%b result=%h readys=%b%b expected 1 0 00000001 00",
                           i, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req0_ready, bus.req1_ready);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_early_grant: got req1_ready=%b expected 0", bus.req1_ready);
    end
    @(negedge clk);
    t1 = cyc;
    n_checks++;
    if (bus.req1_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_next_grant: got req1_ready=%b rsp_valid=%b expected 1 0",
                         bus.req1_ready, bus.rsp_valid);
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_rsp(20, seen, tr);
    n_checks++;
    if (!seen || tr != t1 + 5 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'h1234_5678) begin
      n_fail++; $display("FAIL hold_followup: got cycle=%0d id=%b result=%h expected %0d 1 12345678",
                         tr, bus.rsp_id, bus.rsp_result, t1 + 5);
    end
  endtask

  task automatic test_reset_abort();
    bit seen; int t, tr, rel, t3;
    @(posedge clk); #1;
    do_req(0, 32'h7FFF_FFFF, 32'h1, CMD_ADD, seen, t);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_req(0, 32'hFFFF_FFFF, 32'h1, CMD_ADD, 1'b1);
    drive_req(1, 32'hAAAA_5555, 32'hFFFF_0000, CMD_XOR, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h0 ||
        bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
        {bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero} !== 3'b000) begin
      n_fail++; $display("FAIL abort_reset_values: got valid=%b id=%b result=%h readys=%b%b flags=%b%b%b expected all 0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req0_ready, bus.req1_ready,
                         bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel   = cyc;
    @(negedge clk);
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_prio_reset: got readys=%b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rsp(20, seen, tr);
    n_checks++;
    if (!seen || tr != rel + 5 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h0) begin
      n_fail++; $display("FAIL abort_next_op: got cycle=%0d id=%b result=%h expected %0d 0 00000000",
                         tr, bus.rsp_id, bus.rsp_result, rel + 5);
    end
    n_checks++;
    if ({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero} !== {FL, 1'b0, FL}) begin
      n_fail++; $display("FAIL abort_wrap_flags: got %b%b%b expected %b0%b",
                         bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, FL, FL);
    end
    wait_ready(1, 20, seen, t3);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    n_checks++;
    if (!seen || t3 != tr + 1) begin
      n_fail++; $display("FAIL abort_req1_grant: got seen=%0d cycle=%0d expected %0d", seen, t3, tr + 1);
    end
    wait_rsp(20, seen, tr);
    n_checks++;
    if (!seen || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'h5555_5555) begin
      n_fail++; $display("FAIL abort_req1_result: got seen=%0d id=%b result=%h expected 1 1 55555555",
                         seen, bus.rsp_id, bus.rsp_result);
    end
  endtask

  initial begin
    drive_req(0, 32'h0, 32'h0, CMD_ADD, 1'b0);
    drive_req(1, 32'h0, 32'h0, CMD_ADD, 1'b0);
    bus.rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_arbiter
